// File: rtl/tube_scan_if.sv
// tube_scan_if: signal bundle between a controller and the tube scan driver.
//   en         scan enable (low = display dark)
//   load       one-cycle strobe, capture data_in
//   data_in    32-bit hex word, nibble i = data_in[4i+3:4i]
//   nibble     current digit value towards the segment decoder
//   dig        active-low digit enables
//   frame_done one-cycle pulse after each frame boundary
// master = controller side, slave = tube_scan side.
interface tube_scan_if;
  logic        en;
  logic        load;
  logic [31:0] data_in;
  logic [3:0]  nibble;
  logic [7:0]  dig;
  logic        frame_done;

  modport master (
    output en,
    output load,
    output data_in,
    input  nibble,
    input  dig,
    input  frame_done
  );

  modport slave (
    input  en,
    input  load,
    input  data_in,
    output nibble,
    output dig,
    output frame_done
  );
endinterface

// File: rtl/tube_scan.sv
// tube_scan: multiplexed scan driver for an 8-digit common-anode 7-segment tube.
// Holds a double-buffered hex word and time-slices the digits, each slot starting
// with a dark period to suppress ghosting. New words are swapped in only at frame
// boundaries (or immediately while the display is disabled), so a value never
// appears half-updated.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  tube_scan_if.slave (en, load, data_in in; nibble, dig, frame_done out)
// Parameters: SCAN_DIV cycles per slot (>= 2), BLANK_CYC dark cycles per slot
// (< SCAN_DIV), NUM_DIG digits scanned (1..8).
// Optional: define TUBE_SCAN_LZB_EN for leading-zero blanking.
module tube_scan #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500,
  parameter int unsigned NUM_DIG   = 8
) (
  input  logic       clk,
  input  logic       rst,
  tube_scan_if.slave bus
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);
  localparam logic [2:0]      IdxMax = 3'(NUM_DIG - 1);

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [31:0]     active_q, active_d;
  logic [31:0]     pending_q, pending_d;
  logic            pend_flag_q, pend_flag_d;
  logic [3:0]      nibble_q, nibble_d;
  logic [7:0]      dig_q, dig_d;
  logic            frame_done_q, frame_done_d;

  logic slot_wrap;
  logic frame_end;
  logic suppress;

  assign slot_wrap = (div_cnt_q == DivMax);
  assign frame_end = slot_wrap && (idx_q == IdxMax);

  // State register, including the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      pend_flag_q  <= 1'b0;
      nibble_q     <= 4'h0;
      dig_q        <= 8'hff;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_flag_q  <= pend_flag_d;
      nibble_q     <= nibble_d;
      dig_q        <= dig_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next state: slot/digit counters and the double buffer.
  always_comb begin
    div_cnt_d   = div_cnt_q;
    idx_d       = idx_q;
    active_d    = active_q;
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;

    if (!bus.en) begin
      // Display is dark, so there is nothing to tear: swap straight in.
      div_cnt_d   = '0;
      idx_d       = '0;
      pend_flag_d = 1'b0;
      if (bus.load) begin
        active_d = bus.data_in;
      end else if (pend_flag_q) begin
        active_d = pending_q;
      end
    end else begin
      if (slot_wrap) begin
        div_cnt_d = '0;
        idx_d     = (idx_q == IdxMax) ? 3'd0 : idx_q + 3'd1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end

      if (bus.load) begin
        pending_d   = bus.data_in;
        pend_flag_d = 1'b1;
      end

      if (frame_end) begin
        // A load on the boundary cycle bypasses the pending buffer.
        if (bus.load) begin
          active_d    = bus.data_in;
          pend_flag_d = 1'b0;
        end else if (pend_flag_q) begin
          active_d    = pending_q;
          pend_flag_d = 1'b0;
        end
      end
    end
  end

`ifdef TUBE_SCAN_LZB_EN
  // Suppress digit idx (> 0) when it and every more significant digit are zero.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j < int'(NUM_DIG) && j >= int'(idx_q) && active_q[4*j +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end
    suppress = (idx_q != 3'd0) && upper_zero;
  end
`else
  assign suppress = 1'b0;
`endif

  // Output decode, registered one cycle behind the counters.
  always_comb begin
    nibble_d     = active_q[{idx_q, 2'b00} +: 4];
    dig_d        = 8'hff;
    frame_done_d = 1'b0;
    if (bus.en) begin
      frame_done_d = frame_end;
      if (32'(div_cnt_q) >= BLANK_CYC && !suppress) begin
        dig_d[idx_q] = 1'b0;
      end
    end
  end

  assign bus.nibble     = nibble_q;
  assign bus.dig        = dig_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_tube_scan.sv
// tb_tube_scan: self-checking bench for tube_scan with SCAN_DIV=8, BLANK_CYC=2,
// NUM_DIG=4. A time-based reference model (cycles since scan start, a shown word
// and a last-load-wins pending word) predicts the registered outputs; directed
// scenario tasks add checks against hand-derived values.
module tb_tube_scan;

  localparam int unsigned SD = 8;
  localparam int unsigned BC = 2;
  localparam int unsigned ND = 4;
  localparam int unsigned FR = SD * ND;
  localparam logic [31:0] NMASK = 32'((64'h1 << (4 * ND)) - 64'h1);
`ifdef TUBE_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  tube_scan_if ifc ();

  tube_scan #(
    .SCAN_DIV (SD),
    .BLANK_CYC(BC),
    .NUM_DIG  (ND)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int unsigned m_t;
  logic [31:0] m_shown, m_pend;
  logic        m_has;
  logic [7:0]  exp_dig;
  logic [3:0]  exp_nib;
  logic        exp_fd;

  int unsigned m_pos, m_slot;
  logic        m_bound, m_dark;
  logic [7:0]  m_lit;

  assign m_pos   = m_t % SD;
  assign m_slot  = (m_t / SD) % ND;
  assign m_bound = ((m_t % FR) == FR - 1);
  assign m_lit   = ~(8'h01 << m_slot);
  assign m_dark  = (m_slot != 0) && (((m_shown & NMASK) >> (4 * m_slot)) == 32'h0);

  always @(posedge clk) begin
    if (rst) begin
      m_t     <= 0;
      m_shown <= '0;
      m_pend  <= '0;
      m_has   <= 1'b0;
      exp_dig <= 8'hff;
      exp_nib <= 4'h0;
      exp_fd  <= 1'b0;
    end else begin
      exp_nib <= 4'((m_shown >> (4 * m_slot)) & 32'hf);
      if (!ifc.en) begin
        exp_dig <= 8'hff;
        exp_fd  <= 1'b0;
        m_t     <= 0;
        m_has   <= 1'b0;
        if (ifc.load) m_shown <= ifc.data_in;
        else if (m_has) m_shown <= m_pend;
      end else begin
        exp_fd  <= m_bound;
        exp_dig <= (m_pos < BC || (LZB && m_dark)) ? 8'hff : m_lit;
        m_t     <= (m_t + 1) % FR;
        if (ifc.load) begin
          m_pend <= ifc.data_in;
          m_has  <= 1'b1;
        end
        if (m_bound && (ifc.load || m_has)) begin
          m_shown <= ifc.load ? ifc.data_in : m_pend;
          m_has   <= 1'b0;
        end
      end
    end
  end

  function automatic logic [3:0] nib(input logic [31:0] v, input int s);
    return v[4*s +: 4];
  endfunction

  // Digit s of word v is lit in its slot (leading-zero blanking aware).
  function automatic bit lit_ok(input logic [31:0] v, input int s);
    int h;
    h = -1;
    for (int k = 0; k < int'(ND); k++) if (nib(v, k) != 4'h0) h = k;
    return !LZB || s == 0 || s <= h;
  endfunction

  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifc.frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int lit;
    rst = 1'b1; ifc.en = 1'b1; ifc.load = 1'b1; ifc.data_in = $urandom;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ifc.dig !== 8'hff || ifc.nibble !== 4'h0 || ifc.frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_out cyc=%0d dig=%h nib=%h fd=%b want ff/0/0",
                 i, ifc.dig, ifc.nibble, ifc.frame_done);
      end
    end
    rst = 1'b0; ifc.load = 1'b0;
    lit = 0;
    for (int j = 0; j < int'(FR); j++) begin
      @(negedge clk);
      if (ifc.dig !== 8'hff) lit++;
      checks++;
      if (ifc.dig !== exp_dig || ifc.nibble !== exp_nib || ifc.frame_done !== exp_fd ||
          (ifc.dig !== 8'hff && ifc.nibble !== 4'h0)) begin
        errors++;
        $display("FAIL reset_frame j=%0d dig=%h nib=%h fd=%b want %h/%h/%b",
                 j, ifc.dig, ifc.nibble, ifc.frame_done, exp_dig, exp_nib, exp_fd);
      end
    end
    checks++;
    if (lit != int'(ND * (SD - BC)) && !LZB) begin
      errors++;
      $display("FAIL reset_litcount got %0d want %0d", lit, ND * (SD - BC));
    end
  endtask

  task automatic test_basic();
    logic [7:0] ed;
    @(negedge clk); rst = 1'b1; ifc.load = 1'b0; ifc.en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; ifc.load = 1'b1; ifc.data_in = 32'h1234;
    // Frame 1 still shows the reset value.
    for (int j = 0; j < int'(FR); j++) begin
      @(negedge clk);
      ifc.load = 1'b0;
      checks++;
      if ((ifc.dig !== 8'hff && ifc.nibble !== 4'h0) || ifc.frame_done !== (j == int'(FR) - 1)) begin
        errors++;
        $display("FAIL basic_frame1 j=%0d dig=%h nib=%h fd=%b want nib 0 fd %b",
                 j, ifc.dig, ifc.nibble, ifc.frame_done, j == int'(FR) - 1);
      end
    end
    for (int j = 0; j < 2 * int'(FR); j++) begin
      int s, p;
      @(negedge clk);
      s = (j % int'(FR)) / int'(SD);
      p = j % int'(SD);
      ed = (p < int'(BC)) ? 8'hff : ~(8'h01 << s);
      checks++;
      if (ifc.dig !== ed || (p >= int'(BC) && ifc.nibble !== nib(32'h1234, s)) ||
          ifc.frame_done !== ((j % int'(FR)) == int'(FR) - 1)) begin
        errors++;
        $display("FAIL basic_scan j=%0d dig=%h nib=%h fd=%b want %h/%h/%b", j, ifc.dig,
                 ifc.nibble, ifc.frame_done, ed, nib(32'h1234, s),
                 (j % int'(FR)) == int'(FR) - 1);
      end
    end
  endtask

  task automatic test_tear();
    int a, b;
    a = $urandom_range(12, 2);
    b = $urandom_range(26, a + 2);
    for (int j = 0; j < 2 * int'(FR); j++) begin
      int s;
      logic [31:0] v;
      @(negedge clk);
      ifc.load = 1'b0;
      s = (j % int'(FR)) / int'(SD);
      v = (j < int'(FR)) ? 32'h1234 : 32'h5678;
      checks++;
      if ((ifc.dig !== 8'hff && ifc.nibble !== nib(v, s)) ||
          ifc.frame_done !== ((j % int'(FR)) == int'(FR) - 1)) begin
        errors++;
        $display("FAIL tear j=%0d dig=%h nib=%h fd=%b want nib %h", j, ifc.dig, ifc.nibble,
                 ifc.frame_done, nib(v, s));
      end
      if (j == a) begin ifc.load = 1'b1; ifc.data_in = 32'hABCD; end
      if (j == b) begin ifc.load = 1'b1; ifc.data_in = 32'h5678; end
    end
  endtask

  task automatic test_enable();
    int d;
    bit ok;
    d = 2 * int'(SD) + int'(BC) + int'($urandom_range(4, 0));
    for (int j = 0; j <= d; j++) @(negedge clk);
    checks++;
    if (ifc.dig !== 8'hfb) begin
      errors++;
      $display("FAIL enable_pre dig=%h want fb", ifc.dig);
    end
    ifc.en = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.dig !== 8'hff || ifc.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL enable_off dig=%h fd=%b want ff/0", ifc.dig, ifc.frame_done);
    end
    ifc.load = 1'b1; ifc.data_in = 32'h9;
    @(negedge clk);
    ifc.load = 1'b0;
    repeat (2) @(negedge clk);
    ifc.en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if ((j < 2 && ifc.dig !== 8'hff) || (j == 2 && (ifc.dig !== 8'hfe || ifc.nibble !== 4'h9))) begin
        errors++;
        $display("FAIL enable_on j=%0d dig=%h nib=%h want %s", j, ifc.dig, ifc.nibble,
                 (j < 2) ? "ff" : "fe/9");
      end
    end
    wait_fd(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL enable_fd_timeout got no frame_done want pulse");
    end
  endtask

  task automatic test_boundary();
    for (int j = 0; j < 2 * int'(FR); j++) begin
      int s, p;
      @(negedge clk);
      ifc.load = 1'b0;
      s = (j % int'(FR)) / int'(SD);
      p = j % int'(SD);
      if (j >= int'(FR)) begin
        checks++;
        if (p >= int'(BC) &&
            (ifc.dig !== (lit_ok(32'h00F0, s) ? ~(8'h01 << s) : 8'hff) ||
             ifc.nibble !== nib(32'h00F0, s))) begin
          errors++;
          $display("FAIL boundary_load j=%0d dig=%h nib=%h want nib %h", j, ifc.dig,
                   ifc.nibble, nib(32'h00F0, s));
        end
      end
      if (j == int'(FR) - 2) begin ifc.load = 1'b1; ifc.data_in = 32'h00F0; end
    end
  endtask

  task automatic test_lzb();
    logic [31:0] vals [2];
    vals[0] = 32'h0040;
    vals[1] = 32'h0000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); ifc.en = 1'b0; ifc.load = 1'b1; ifc.data_in = vals[k];
      @(negedge clk); ifc.load = 1'b0; ifc.en = 1'b1;
      for (int j = 0; j < int'(FR); j++) begin
        int s, p;
        logic [7:0] ed;
        @(negedge clk);
        s = j / int'(SD);
        p = j % int'(SD);
        ed = (p < int'(BC) || !lit_ok(vals[k], s)) ? 8'hff : ~(8'h01 << s);
        checks++;
        if (ifc.dig !== ed || (ed !== 8'hff && ifc.nibble !== nib(vals[k], s))) begin
          errors++;
          $display("FAIL lzb v=%h j=%0d dig=%h nib=%h want %h/%h", vals[k], j, ifc.dig,
                   ifc.nibble, ed, nib(vals[k], s));
        end
      end
    end
  endtask

  task automatic test_random();
    @(negedge clk); rst = 1'b1; ifc.en = 1'b1; ifc.load = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      checks++;
      if (ifc.dig !== exp_dig || ifc.nibble !== exp_nib || ifc.frame_done !== exp_fd) begin
        errors++;
        $display("FAIL random i=%0d dig=%h nib=%h fd=%b want %h/%h/%b", i, ifc.dig,
                 ifc.nibble, ifc.frame_done, exp_dig, exp_nib, exp_fd);
      end
      rst = ($urandom_range(299, 0) == 0);
      if ($urandom_range(39, 0) == 0) ifc.en = ~ifc.en;
      ifc.load    = ($urandom_range(9, 0) == 0);
      ifc.data_in = $urandom;
    end
    rst = 1'b0; ifc.load = 1'b0;
  endtask

  initial begin
    ifc.en = 1'b1;
    ifc.load = 1'b0;
    ifc.data_in = '0;
    test_reset();
    test_basic();
    test_tear();
    test_enable();
    test_boundary();
    test_lzb();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tube_scan.md
Name: tube_scan

Overview:
- Multiplexed scan driver for the board's 8-digit common-anode 7-segment tube.
- Holds a displayed word of up to 8 hex nibbles and time-slices the digits.
- Drives the current digit's nibble into the existing single-digit segment decoder, and drives the active-low digit enables directly.
- Frame-synchronous double buffering: a new value never appears half-updated across digits.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (1 ms at 50 MHz); must be >= 2.
- BLANK_CYC, 500, dark cycles at the start of each slot (anti-ghosting); must be < SCAN_DIV.
- NUM_DIG, 8, digits scanned (1..8); digit 0 = least-significant nibble = dig[0].

Ports:
- clk  in  1  system clock; sole clock of the block.
- rst  in  1  reset: synchronous, active-high.
- en  in  1  scan enable; low = display dark.
- load  in  1  one-cycle strobe: capture data_in.
- data_in  in  32  hex word; nibble i = data_in[4i+3:4i].
- nibble  out  4  current digit's value, to the segment decoder's A input.
- dig  out  8  digit enables, active-low (0 = digit lit).
- frame_done  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset (rst high at a clk edge, including mid-operation):
  - div_cnt=0, idx=0, active=0, pending=0, pend_flag=0.
  - Outputs: nibble=4'h0, dig=8'hff, frame_done=0.
  - A pending load is discarded.
- Slot counter:
  - With en=1, div_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, idx <= (idx==NUM_DIG-1) ? 0 : idx+1.
  - Frame boundary = the cycle with div_cnt==SCAN_DIV-1 and idx==NUM_DIG-1.
- Outputs are registered and lag counter state by exactly one clk:
  - nibble = active[4*idx +: 4].
  - dig = 8'hff while div_cnt < BLANK_CYC.
  - Otherwise dig bit idx = 0 and all other bits = 1.
  - dig bits >= NUM_DIG are always 1.
- Load / double buffer:
  - load=1 sets pending<=data_in and pend_flag<=1.
  - Several loads within one frame: the last one wins.
  - At the frame boundary, if pend_flag is set, then active<=pending and pend_flag<=0.
  - If load coincides with the boundary, that cycle's data_in goes straight to active.
  - The new value is visible from digit 0 of the next frame.
- frame_done:
  - 1 for exactly one cycle, registered, in the cycle after each frame boundary.
  - Never asserted while en=0.
- en=0:
  - Next cycle: dig=8'hff and frame_done=0.
  - div_cnt and idx held at 0.
  - Loads are still accepted; pending transfers to active immediately, since the display is dark and no tearing is possible.
- en 0->1: scanning restarts at idx 0, div_cnt 0, beginning with the full blank period.
- NUM_DIG=1: every slot wrap is a frame boundary, and digit 0 is lit continuously apart from the blank periods.

Optional Feature:
- Macro: TUBE_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - During the slot of digit i > 0, dig stays 8'hff if active nibbles i..NUM_DIG-1 are all 0.
  - Digit 0 is never suppressed.
  - Slot timing and frame_done are unchanged.
- Undefined: every digit 0..NUM_DIG-1 is lit in its slot.

Test Plan (SCAN_DIV=8, BLANK_CYC=2, NUM_DIG=4 unless noted):
- Reset: hold rst 3 cycles with en=1 and load=1 -> dig=8'hff, nibble=0, frame_done=0. First frame after release shows 0 on all digits.
- Basic scan: load 32'h1234 at reset release.
  - Frame 1 shows 0000.
  - From frame 2, each slot gives 2 cycles of dig=ff, then 6 cycles of fe/fd/fb/f7 with nibble 4/3/2/1 respectively.
  - frame_done pulses every 32 cycles.
- Tear-free: mid-frame load 32'hABCD, then load 32'h5678 in the same frame -> current frame unchanged; next frame shows nibbles 8,7,6,5; A..D never appear.
- Enable: drop en during digit 2's lit period -> dig=ff next cycle. Load 32'h9 while en=0, then raise en -> after 2 blank cycles dig=fe with nibble 9.
- Boundary load: assert load with 32'h00F0 exactly on the boundary cycle -> next frame's digit 1 shows F.
- LZB (macro defined): active=32'h0040 -> digits 0 and 1 lit (0, 4) and slots 2,3 dark. active=0 -> only digit 0 lit. Without the macro, all four digits are lit in both cases.
